mem_port_arbiter: RTL

Two-requester arbiter that shares the single-port 16-bit `sram` between the CPU instruction-fetch port (read-only) and the data-memory port (read/write). It sits between the pipeline and the `sram` instance. It grants at most one access per cycle and registers the winning command onto the SRAM pins. Read data is returned to the owning port with a fixed two-cycle latency. Data port has default priority; a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline ports, the arbiter and the shared sram.
// The slave modport is the arbiter's view; master is the pipeline/sram side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvalid;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_rvalid;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_data_in;
  logic              sram_we;
  logic [DATA_W-1:0] sram_data_out;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_data_out,
    output if_gnt, if_rdata, if_rvalid, dm_gnt, dm_rdata, dm_rvalid,
           sram_addr, sram_data_in, sram_we
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_data_out,
    input  if_gnt, if_rdata, if_rvalid, dm_gnt, dm_rdata, dm_rvalid,
           sram_addr, sram_data_in, sram_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sram between the instruction-fetch port and the
// data port. One access per cycle, command registered onto the sram pins,
// read data returned to its owner two cycles after the grant. The data port
// wins ties unless fetch has been starved for STARVE_LIMIT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {PRIO_D, PRIO_I} prio_e;

  localparam logic [7:0] STARVE_LAST = 8'(STARVE_LIMIT - 1);

  prio_e             state, state_nxt;
  logic [7:0]        starve_cnt, starve_nxt;
  logic              if_gnt, dm_gnt;

  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              we_p1;
  logic              tag_vld_p1;
  logic              tag_own_p1;   // 1 = fetch owns the read

  logic [DATA_W-1:0] if_rdata_p2, dm_rdata_p2;
  logic              if_vld_p2, dm_vld_p2;

  // Grant selection, starvation counting and priority next-state.
  // The counter clears on the switch to PRIO_I: by then its job is done,
  // and this keeps it within 0..STARVE_LIMIT-1.
  always_comb begin
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;
    if (rst) begin
      state_nxt  = PRIO_D;
      starve_nxt = 8'd0;
    end else begin
      if_gnt = bus.if_req & (~bus.dm_req | (state == PRIO_I));
      dm_gnt = bus.dm_req & ~if_gnt;
      if (bus.if_req && !if_gnt) starve_nxt = starve_cnt + 8'd1;
      else                       starve_nxt = 8'd0;
      case (state)
        PRIO_D: if (bus.if_req && !if_gnt && starve_cnt == STARVE_LAST) begin
                  state_nxt  = PRIO_I;
                  starve_nxt = 8'd0;
                end
        PRIO_I: if (if_gnt || !bus.if_req) state_nxt = PRIO_D;
        default: state_nxt = PRIO_D;
      endcase
    end
  end

  // Priority state and starvation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRIO_D;
      starve_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Stage p1: register the winning command onto the sram pins and tag reads.
  // A fetch has no write data, so sram_data_in keeps its previous value.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p1    <= '0;
      wdata_p1   <= '0;
      we_p1      <= 1'b0;
      tag_vld_p1 <= 1'b0;
      tag_own_p1 <= 1'b0;
    end else begin
      tag_vld_p1 <= if_gnt | (dm_gnt & ~bus.dm_we);
      tag_own_p1 <= if_gnt;
      if (dm_gnt) begin
        addr_p1  <= bus.dm_addr;
        wdata_p1 <= bus.dm_wdata;
        we_p1    <= bus.dm_we;
      end else if (if_gnt) begin
        addr_p1  <= bus.if_addr;
        we_p1    <= 1'b0;
      end else begin
        we_p1    <= 1'b0;
      end
    end
  end

  // Stage p2: capture sram read data into the owning port and pulse its valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_p2 <= '0;
      dm_rdata_p2 <= '0;
      if_vld_p2   <= 1'b0;
      dm_vld_p2   <= 1'b0;
    end else begin
      if_vld_p2 <= tag_vld_p1 & tag_own_p1;
      dm_vld_p2 <= tag_vld_p1 & ~tag_own_p1;
      if (tag_vld_p1 && tag_own_p1)  if_rdata_p2 <= bus.sram_data_out;
      if (tag_vld_p1 && !tag_own_p1) dm_rdata_p2 <= bus.sram_data_out;
    end
  end

  assign bus.if_gnt       = if_gnt;
  assign bus.dm_gnt       = dm_gnt;
  assign bus.sram_addr    = addr_p1;
  assign bus.sram_data_in = wdata_p1;
  assign bus.sram_we      = we_p1;
  assign bus.if_rdata     = if_rdata_p2;
  assign bus.if_rvalid    = if_vld_p2;
  assign bus.dm_rdata     = dm_rdata_p2;
  assign bus.dm_rvalid    = dm_vld_p2;

endmodule
